i2c_target_regfile: RTL and testbench
=====================================

// Module: i2c_target_regfile
// PURPOSE
//  Downstream stage of the I2C APB master. Acts as an I2C target on the bus that the
//  master's scl_out/sda_out drive. Oversamples SCL/SDA on core_clk, decodes START/STOP,
//  matches a 7-bit address and serves an 8-byte register file with an auto-incrementing
//  pointer. Write format: addr+W, pointer, data...; read format: addr+R, data from pointer.
// PARAMETERS
//  SLAVE_ADDR     7'h50  7-bit target address matched against the first byte after START
//  data_size      8      register width in bits (the byte-serial logic requires 8)
//  address_size   3      pointer width; register file depth = 2**address_size
// PORTS
//  core_clk   in   1               single clock; must be >= 8x the SCL frequency
//  rst        in   1               asynchronous, active-high reset
//  scl_in     in   1               raw SCL from the bus (asynchronous)
//  sda_in     in   1               raw SDA from the bus (asynchronous)
//  sda_out    out  1               open-drain SDA drive: 0 = pull low, 1 = release
//  busy       out  1               high from a START with address match until STOP or NACK
//  wr_strobe  out  1               one-cycle pulse when a data byte is written to the file
//  wr_addr    out  address_size    register index written (valid with wr_strobe)
//  wr_data    out  data_size       byte written (valid with wr_strobe)
//  dbg_addr   in   address_size    host-side peek index
//  dbg_data   out  data_size       combinational regfile[dbg_addr]
// BEHAVIOUR
//  - Reset: sda_out=1, busy=0, wr_strobe=0, wr_addr=0, wr_data=0, pointer=0, all regs=0,
//    state=IDLE. Asserting reset mid-transfer aborts the transfer and releases SDA at once.
//  - Input path: 2-FF synchroniser on scl_in and sda_in, then a 1-FF history for edge
//    detection. A detected edge is seen 3 core_clk after the raw edge.
//  - START: synced SDA falls while SCL is high on both the current and previous sample.
//    STOP: synced SDA rises under the same condition. START from any state goes to ADDR
//    and clears the bit counter; this covers repeated start. STOP from any state goes to
//    IDLE and sets sda_out=1 and busy=0. The pointer is kept across STOP and START.
//  - Bits are sampled on the synced SCL rising edge, MSB first. sda_out changes only in the
//    cycle after a detected SCL falling edge, never while SCL is high.
//  - States:
//    IDLE      : wait for START.
//    ADDR      : shift in 8 bits. If bits[7:1]==SLAVE_ADDR go to ADDR_ACK, else go to
//                IGNORE (sda_out stays 1).
//    ADDR_ACK  : on the next SCL fall drive 0 and set busy=1. On the following SCL fall:
//                RW=0 -> release SDA and go to PTR; RW=1 -> drive MSB of regfile[pointer]
//                and go to RDATA.
//    PTR       : shift in 8 bits; pointer <= byte[address_size-1:0]; go to PTR_ACK.
//    PTR_ACK   : ACK as in ADDR_ACK, then go to WDATA.
//    WDATA     : shift in 8 bits. After the 8th rising edge, write regfile[pointer]. In the
//                same cycle assert wr_strobe/wr_addr/wr_data and set
//                pointer <= pointer+1 (wraps 7->0). Then go to WDATA_ACK.
//    WDATA_ACK : ACK, then return to WDATA.
//    RDATA     : drive bits 6..0 on the next 7 SCL falls. On the 8th fall release SDA and
//                go to RACK.
//    RACK      : sample the master bit on the SCL rise. 0 (ACK): pointer+1 (wrap), drive
//                MSB of the new byte on the SCL fall, go to RDATA. 1 (NACK): pointer+1,
//                busy=0, go to IGNORE.
//    IGNORE    : sda_out=1; wait for START or STOP.
//  - The read byte is latched into a shift register when RDATA is entered. A concurrent
//    write cannot occur; dbg reads have no side effects.
//  - If SCL and SDA change in the same sample, it is not a START/STOP. It is a data edge.
// TESTING
//  1 Write: START, 0xA0, 0x02, 0x11, 0x22, STOP -> ACK on all 4 bytes;
//    reg[2]=0x11, reg[3]=0x22; two wr_strobe pulses with wr_addr 2 then 3; busy=0 after STOP.
//  2 Wrap: pointer 0x07, write 0x5A, 0x6B -> reg[7]=0x5A, reg[0]=0x6B; pointer ends at 1.
//  3 Read with repeated start: START, 0xA0, 0x03, rSTART, 0xA1, master ACK, ACK, NACK,
//    STOP -> target returns reg[3], reg[4], reg[5]; SDA released after the NACK.
//  4 Address mismatch: START, 0xA2, 0x00, 0xFF, STOP -> sda_out stays 1 throughout,
//    busy stays 0, no wr_strobe, regfile unchanged.
//  5 Abort: assert rst during the 4th data bit of a write -> sda_out=1 in the same cycle;
//    regs=0; the next full transaction ACKs normally.
//  6 Glitch/timing: SDA changes while SCL is low at 8 core_clk per SCL half-period ->
//    no false START/STOP; the sda_out change lags the raw SCL fall by exactly 4 core_clk.

Source files
------------

// File: rtl/i2c_target_regfile.sv
// ----------------------------------------------------------------------------
// i2c_target_regfile
//
// I2C target that serves a small register file. It oversamples SCL/SDA on
// core_clk, decodes START/STOP, matches a 7-bit address and then either
// accepts a pointer byte followed by data bytes (write), or returns bytes
// starting at the pointer (read). The pointer auto-increments and wraps, and
// it is kept across STOP and START.
//
// Ports
//   core_clk  : single clock, at least 8x the SCL frequency
//   rst       : asynchronous active-high reset
//   scl_in    : raw SCL from the bus (asynchronous)
//   sda_in    : raw SDA from the bus (asynchronous)
//   sda_out   : open-drain SDA drive, 0 = pull low, 1 = release
//   busy      : high from an address-matched ACK until STOP or read NACK
//   wr_strobe : one-cycle pulse when a data byte is written to the file
//   wr_addr   : register index written (valid with wr_strobe)
//   wr_data   : byte written (valid with wr_strobe)
//   dbg_addr  : host-side peek index
//   dbg_data  : combinational regfile[dbg_addr]
// ----------------------------------------------------------------------------
module i2c_target_regfile #(
   parameter logic [6:0] SLAVE_ADDR   = 7'h50,
   parameter int         data_size    = 8,
   parameter int         address_size = 3
) (
   input  logic                    core_clk,
   input  logic                    rst,
   input  logic                    scl_in,
   input  logic                    sda_in,
   output logic                    sda_out,
   output logic                    busy,
   output logic                    wr_strobe,
   output logic [address_size-1:0] wr_addr,
   output logic [data_size-1:0]    wr_data,
   input  logic [address_size-1:0] dbg_addr,
   output logic [data_size-1:0]    dbg_data
);

   localparam int DEPTH = 2 ** address_size;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WDATA,
      ST_WDATA_ACK,
      ST_RDATA,
      ST_RACK,
      ST_IGNORE
   } state_t;

   // ------------------------------------------------------------------------
   // Input conditioning: 2-FF synchronisers plus one history stage. Bus
   // events are registered so the FSM sees them 3 core_clk after the raw
   // edge, which puts every sda_out update 4 core_clk after a raw SCL fall.
   // ------------------------------------------------------------------------
   logic r_scl_s1, r_scl_s2, r_scl_d;
   logic r_sda_s1, r_sda_s2, r_sda_d;
   logic r_scl_rise, r_scl_fall, r_start, r_stop, r_bit;

   always_ff @(posedge core_clk or posedge rst) begin
      if (rst) begin
         r_scl_s1   <= 1'b1;
         r_scl_s2   <= 1'b1;
         r_scl_d    <= 1'b1;
         r_sda_s1   <= 1'b1;
         r_sda_s2   <= 1'b1;
         r_sda_d    <= 1'b1;
         r_scl_rise <= 1'b0;
         r_scl_fall <= 1'b0;
         r_start    <= 1'b0;
         r_stop     <= 1'b0;
         r_bit      <= 1'b1;
      end else begin
         r_scl_s1   <= scl_in;
         r_scl_s2   <= r_scl_s1;
         r_scl_d    <= r_scl_s2;
         r_sda_s1   <= sda_in;
         r_sda_s2   <= r_sda_s1;
         r_sda_d    <= r_sda_s2;
         r_scl_rise <= r_scl_s2 & ~r_scl_d;
         r_scl_fall <= ~r_scl_s2 & r_scl_d;
         // SCL must be high on both samples, so an SDA edge that lands in
         // the same sample as an SCL edge counts as data, not START/STOP.
         r_start    <= r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
         r_stop     <= r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
         r_bit      <= r_sda_s2;
      end
   end

   // ------------------------------------------------------------------------
   // Protocol state
   // ------------------------------------------------------------------------
   state_t                  r_state, w_state_next;
   logic [2:0]              r_cnt, w_cnt_next;
   logic [data_size-1:0]    r_rx, w_rx_next;
   logic [data_size-1:0]    r_tx, w_tx_next;
   logic [address_size-1:0] r_ptr, w_ptr_next;
   logic                    r_sda, w_sda_next;
   logic                    r_busy, w_busy_next;
   // Splits each ACK slot into "drive on first fall" / "finish on next fall"
   // and, in RACK, "wait for master bit" / "wait for fall to drive MSB".
   logic                    r_ack_ph, w_ack_ph_next;
   logic                    w_we;
   logic [data_size-1:0]    w_rx_byte;
   logic [data_size-1:0]    w_rd_byte;

   logic [data_size-1:0]    r_regs [DEPTH];
   logic                    r_wr_strobe;
   logic [address_size-1:0] r_wr_addr;
   logic [data_size-1:0]    r_wr_data;

   assign w_rx_byte = {r_rx[data_size-2:0], r_bit};
   assign w_rd_byte = r_regs[r_ptr];

   always_comb begin
      w_state_next  = r_state;
      w_cnt_next    = r_cnt;
      w_rx_next     = r_rx;
      w_tx_next     = r_tx;
      w_ptr_next    = r_ptr;
      w_sda_next    = r_sda;
      w_busy_next   = r_busy;
      w_ack_ph_next = r_ack_ph;
      w_we          = 1'b0;

      if (r_stop) begin
         w_state_next = ST_IDLE;
         w_sda_next   = 1'b1;
         w_busy_next  = 1'b0;
      end else if (r_start) begin
         // Also covers repeated START: restart address reception.
         w_state_next  = ST_ADDR;
         w_cnt_next    = 3'd0;
         w_sda_next    = 1'b1;
         w_ack_ph_next = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
            end

            ST_ADDR: begin
               if (r_scl_rise) begin
                  w_rx_next  = w_rx_byte;
                  w_cnt_next = r_cnt + 3'd1;
                  if (r_cnt == 3'd7) begin
                     w_ack_ph_next = 1'b0;
                     if (w_rx_byte[data_size-1:1] == SLAVE_ADDR) begin
                        w_state_next = ST_ADDR_ACK;
                     end else begin
                        // Someone else's transfer: we are no longer addressed.
                        w_state_next = ST_IGNORE;
                        w_busy_next  = 1'b0;
                     end
                  end
               end
            end

            ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
               if (r_scl_fall) begin
                  if (!r_ack_ph) begin
                     w_sda_next    = 1'b0;
                     w_ack_ph_next = 1'b1;
                     if (r_state == ST_ADDR_ACK) begin
                        w_busy_next = 1'b1;
                     end
                  end else begin
                     w_ack_ph_next = 1'b0;
                     w_cnt_next    = 3'd0;
                     w_sda_next    = 1'b1;
                     if (r_state == ST_ADDR_ACK) begin
                        // r_rx still holds the address byte; bit 0 is R/W.
                        if (r_rx[0]) begin
                           w_tx_next    = w_rd_byte;
                           w_sda_next   = w_rd_byte[data_size-1];
                           w_state_next = ST_RDATA;
                        end else begin
                           w_state_next = ST_PTR;
                        end
                     end else begin
                        w_state_next = ST_WDATA;
                     end
                  end
               end
            end

            ST_PTR: begin
               if (r_scl_rise) begin
                  w_rx_next  = w_rx_byte;
                  w_cnt_next = r_cnt + 3'd1;
                  if (r_cnt == 3'd7) begin
                     w_ptr_next    = w_rx_byte[address_size-1:0];
                     w_ack_ph_next = 1'b0;
                     w_state_next  = ST_PTR_ACK;
                  end
               end
            end

            ST_WDATA: begin
               if (r_scl_rise) begin
                  w_rx_next  = w_rx_byte;
                  w_cnt_next = r_cnt + 3'd1;
                  if (r_cnt == 3'd7) begin
                     w_we          = 1'b1;
                     w_ptr_next    = r_ptr + address_size'(1);
                     w_ack_ph_next = 1'b0;
                     w_state_next  = ST_WDATA_ACK;
                  end
               end
            end

            ST_RDATA: begin
               if (r_scl_fall) begin
                  if (r_cnt == 3'd7) begin
                     // Byte done: release so the master can ACK/NACK.
                     w_sda_next    = 1'b1;
                     w_cnt_next    = 3'd0;
                     w_ack_ph_next = 1'b0;
                     w_state_next  = ST_RACK;
                  end else begin
                     w_sda_next = r_tx[data_size-2];
                     w_tx_next  = {r_tx[data_size-2:0], 1'b0};
                     w_cnt_next = r_cnt + 3'd1;
                  end
               end
            end

            ST_RACK: begin
               if (!r_ack_ph) begin
                  if (r_scl_rise) begin
                     w_ptr_next = r_ptr + address_size'(1);
                     if (r_bit) begin
                        w_busy_next  = 1'b0;
                        w_state_next = ST_IGNORE;
                     end else begin
                        w_ack_ph_next = 1'b1;
                     end
                  end
               end else if (r_scl_fall) begin
                  // Pointer has already advanced; latch the next byte now.
                  w_tx_next     = w_rd_byte;
                  w_sda_next    = w_rd_byte[data_size-1];
                  w_cnt_next    = 3'd0;
                  w_ack_ph_next = 1'b0;
                  w_state_next  = ST_RDATA;
               end
            end

            ST_IGNORE: begin
               w_sda_next = 1'b1;
            end

            default: begin
               w_state_next = ST_IDLE;
               w_sda_next   = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge core_clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_cnt    <= 3'd0;
         r_rx     <= '0;
         r_tx     <= '0;
         r_ptr    <= '0;
         r_sda    <= 1'b1;
         r_busy   <= 1'b0;
         r_ack_ph <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_cnt    <= w_cnt_next;
         r_rx     <= w_rx_next;
         r_tx     <= w_tx_next;
         r_ptr    <= w_ptr_next;
         r_sda    <= w_sda_next;
         r_busy   <= w_busy_next;
         r_ack_ph <= w_ack_ph_next;
      end
   end

   // ------------------------------------------------------------------------
   // Register file and write notification. Reads are combinational so the
   // host peek port and the read path see the current contents.
   // ------------------------------------------------------------------------
   always_ff @(posedge core_clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_we) begin
         r_regs[r_ptr] <= w_rx_byte;
      end
   end

   always_ff @(posedge core_clk or posedge rst) begin
      if (rst) begin
         r_wr_strobe <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
      end else begin
         r_wr_strobe <= w_we;
         if (w_we) begin
            r_wr_addr <= r_ptr;
            r_wr_data <= w_rx_byte;
         end
      end
   end

   assign sda_out   = r_sda;
   assign busy      = r_busy;
   assign wr_strobe = r_wr_strobe;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;
   assign dbg_data  = r_regs[dbg_addr];

endmodule

// File: tb/tb_i2c_target_regfile.sv
// ----------------------------------------------------------------------------
// tb_i2c_target_regfile
//
// Plays the I2C master with an 8 core_clk SCL half-period and resolves the
// open-drain SDA bus as master AND target. Write transactions come from a
// vector table; reads, repeated start, timing, glitch and reset-abort cases
// are hand-written sequences.
// ----------------------------------------------------------------------------
module tb_i2c_target_regfile;

   logic       core_clk = 1'b0;
   logic       rst      = 1'b1;
   logic       scl_in   = 1'b1;
   logic       m_sda    = 1'b1;
   logic       sda_in;
   logic       sda_out;
   logic       busy;
   logic       wr_strobe;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;
   logic [2:0] dbg_addr = 3'd0;
   logic [7:0] dbg_data;

   assign sda_in = m_sda & sda_out;

   always #5 core_clk = ~core_clk;

   i2c_target_regfile #(
      .SLAVE_ADDR  (7'h50),
      .data_size   (8),
      .address_size(3)
   ) dut (
      .core_clk (core_clk),
      .rst      (rst),
      .scl_in   (scl_in),
      .sda_in   (sda_in),
      .sda_out  (sda_out),
      .busy     (busy),
      .wr_strobe(wr_strobe),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: sole writer of these; the test takes snapshots and deltas.
   int         strobe_cnt = 0;
   int         low_cnt    = 0;
   logic [2:0] q_wa[$];
   logic [7:0] q_wd[$];

   always @(negedge core_clk) begin
      if (wr_strobe === 1'b1) begin
         strobe_cnt++;
         q_wa.push_back(wr_addr);
         q_wd.push_back(wr_data);
      end
      if (sda_out === 1'b0) low_cnt++;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- bus master tasks ----------------
   task automatic wait_clk(input int n);
      repeat (n) @(posedge core_clk);
      #1;
   endtask

   task automatic i2c_start();
      m_sda = 1'b0;
      wait_clk(8);
      scl_in = 1'b0;
      wait_clk(4);
   endtask

   task automatic i2c_rstart();
      m_sda = 1'b1;
      wait_clk(4);
      scl_in = 1'b1;
      wait_clk(8);
      i2c_start();
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0;
      wait_clk(4);
      scl_in = 1'b1;
      wait_clk(8);
      m_sda = 1'b1;
      wait_clk(8);
   endtask

   task automatic send_bit(input logic b);
      m_sda = b;
      wait_clk(4);
      scl_in = 1'b1;
      wait_clk(8);
      scl_in = 1'b0;
      wait_clk(4);
   endtask

   // meas: check that the ACK drive appears exactly 4 core_clk after SCL falls.
   task automatic write_byte(input logic [7:0] b, input bit meas, output logic ack);
      for (int i = 7; i >= 1; i--) send_bit(b[i]);
      m_sda = b[0];
      wait_clk(4);
      scl_in = 1'b1;
      wait_clk(8);
      scl_in = 1'b0;
      if (meas) begin
         wait_clk(3);
         check("lag3_sda_released", 32'(sda_out), 32'(1'b1));
         wait_clk(1);
         check("lag4_sda_driven", 32'(sda_out), 32'(1'b0));
      end else begin
         wait_clk(4);
      end
      m_sda = 1'b1;
      wait_clk(4);
      scl_in = 1'b1;
      wait_clk(4);
      ack = ~sda_in;
      wait_clk(4);
      scl_in = 1'b0;
      wait_clk(4);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic nack);
      for (int i = 7; i >= 0; i--) begin
         m_sda = 1'b1;
         wait_clk(4);
         scl_in = 1'b1;
         wait_clk(4);
         d[i] = sda_in;
         wait_clk(4);
         scl_in = 1'b0;
         wait_clk(4);
      end
      m_sda = nack;
      wait_clk(4);
      scl_in = 1'b1;
      wait_clk(8);
      scl_in = 1'b0;
      wait_clk(4);
   endtask

   // ---------------- write vector table ----------------
   typedef struct {
      logic [7:0] a;     // address byte
      logic [7:0] p;     // pointer byte
      int         nd;    // number of data bytes (1 or 2)
      logic [7:0] d0;
      logic [7:0] d1;
      logic       ack;   // expected ACK on every byte
      int         ns;    // expected wr_strobe pulses
      logic [2:0] wa0;   // expected wr_addr of each pulse
      logic [2:0] wa1;
   } wvec_t;

   wvec_t      tv[5];
   logic [7:0] exp_regs[8];

   initial begin
      logic       ack;
      logic [7:0] rd;
      logic [7:0] ed;
      logic [2:0] ea;
      int         s0, l0, qb;

      tv[0] = '{8'hA0, 8'h02, 2, 8'h11, 8'h22, 1'b1, 2, 3'd2, 3'd3};
      tv[1] = '{8'hA0, 8'h04, 2, 8'h44, 8'h55, 1'b1, 2, 3'd4, 3'd5};
      tv[2] = '{8'hA0, 8'hF9, 1, 8'hC3, 8'h00, 1'b1, 1, 3'd1, 3'd0};
      tv[3] = '{8'hA0, 8'h07, 2, 8'h5A, 8'h6B, 1'b1, 2, 3'd7, 3'd0};
      tv[4] = '{8'hA2, 8'h00, 1, 8'hFF, 8'h00, 1'b0, 0, 3'd0, 3'd0};
      exp_regs = '{8'h6B, 8'hC3, 8'h11, 8'h22, 8'h44, 8'h55, 8'h00, 8'h5A};

      wait_clk(4);
      rst = 1'b0;
      wait_clk(4);

      check("reset_sda_out", 32'(sda_out), 32'(1'b1));
      check("reset_busy", 32'(busy), 32'(1'b0));
      check("reset_wr_strobe", 32'(wr_strobe), 32'(1'b0));
      check("reset_wr_addr", 32'(wr_addr), 32'(3'd0));
      check("reset_wr_data", 32'(wr_data), 32'(8'h00));
      check("reset_dbg_data", 32'(dbg_data), 32'(8'h00));
      $display("reset: sda_out=%0b busy=%0b", sda_out, busy);

      // ---- table-driven write transactions ----
      for (int v = 0; v < 5; v++) begin
         s0 = strobe_cnt;
         l0 = low_cnt;
         qb = q_wa.size();
         i2c_start();
         write_byte(tv[v].a, v == 0, ack);
         check("vec_addr_ack", 32'(ack), 32'(tv[v].ack));
         check("vec_busy_mid", 32'(busy), 32'(tv[v].ack));
         write_byte(tv[v].p, 1'b0, ack);
         check("vec_ptr_ack", 32'(ack), 32'(tv[v].ack));
         for (int j = 0; j < tv[v].nd; j++) begin
            write_byte((j == 0) ? tv[v].d0 : tv[v].d1, 1'b0, ack);
            check("vec_data_ack", 32'(ack), 32'(tv[v].ack));
         end
         i2c_stop();
         check("vec_busy_after_stop", 32'(busy), 32'(1'b0));
         check("vec_strobe_count", 32'(strobe_cnt - s0), 32'(tv[v].ns));
         for (int k = 0; k < tv[v].ns; k++) begin
            if (qb + k < q_wa.size()) begin
               ea = (k == 0) ? tv[v].wa0 : tv[v].wa1;
               ed = (k == 0) ? tv[v].d0 : tv[v].d1;
               check("vec_wr_addr", 32'(q_wa[qb + k]), 32'(ea));
               check("vec_wr_data", 32'(q_wd[qb + k]), 32'(ed));
            end
         end
         check("vec_sda_pulled_low", 32'(low_cnt != l0), 32'(tv[v].ack));
         $display("write vec %0d: addr=%02h ptr=%02h strobes=%0d busy=%0b",
                  v, tv[v].a, tv[v].p, strobe_cnt - s0, busy);
      end

      for (int r = 0; r < 8; r++) begin
         dbg_addr = 3'(r);
         #1;
         check("regfile_after_writes", 32'(dbg_data), 32'(exp_regs[r]));
      end

      // ---- read without pointer: pointer must have wrapped to 1 ----
      i2c_start();
      write_byte(8'hA1, 1'b0, ack);
      check("ptrread_addr_ack", 32'(ack), 32'(1'b1));
      read_byte(rd, 1'b1);
      check("ptrread_data", 32'(rd), 32'(8'hC3));
      check("ptrread_sda_released", 32'(sda_out), 32'(1'b1));
      check("ptrread_busy_after_nack", 32'(busy), 32'(1'b0));
      i2c_stop();
      $display("read after wrap: data=%02h", rd);

      // ---- read with repeated start ----
      s0 = strobe_cnt;
      i2c_start();
      write_byte(8'hA0, 1'b0, ack);
      check("rs_addr_w_ack", 32'(ack), 32'(1'b1));
      write_byte(8'h03, 1'b0, ack);
      check("rs_ptr_ack", 32'(ack), 32'(1'b1));
      i2c_rstart();
      write_byte(8'hA1, 1'b0, ack);
      check("rs_addr_r_ack", 32'(ack), 32'(1'b1));
      read_byte(rd, 1'b0);
      check("rs_read0", 32'(rd), 32'(8'h22));
      check("rs_busy_during_read", 32'(busy), 32'(1'b1));
      read_byte(rd, 1'b0);
      check("rs_read1", 32'(rd), 32'(8'h44));
      read_byte(rd, 1'b1);
      check("rs_read2", 32'(rd), 32'(8'h55));
      check("rs_sda_released_after_nack", 32'(sda_out), 32'(1'b1));
      check("rs_busy_after_nack", 32'(busy), 32'(1'b0));
      i2c_stop();
      check("rs_no_strobe", 32'(strobe_cnt - s0), 32'(0));
      $display("read with repeated start: last=%02h", rd);

      // ---- timing and SDA activity while SCL is low ----
      s0 = strobe_cnt;
      qb = q_wa.size();
      i2c_start();
      write_byte(8'hA0, 1'b1, ack);
      check("glitch_addr_ack", 32'(ack), 32'(1'b1));
      write_byte(8'h06, 1'b0, ack);
      check("glitch_ptr_ack", 32'(ack), 32'(1'b1));
      for (int g = 0; g < 6; g++) begin
         m_sda = ~m_sda;
         wait_clk(1);
      end
      wait_clk(4);
      check("glitch_busy_kept", 32'(busy), 32'(1'b1));
      write_byte(8'h77, 1'b0, ack);
      check("glitch_data_ack", 32'(ack), 32'(1'b1));
      i2c_stop();
      check("glitch_strobe_count", 32'(strobe_cnt - s0), 32'(1));
      if (qb < q_wa.size()) begin
         check("glitch_wr_addr", 32'(q_wa[qb]), 32'(3'd6));
         check("glitch_wr_data", 32'(q_wd[qb]), 32'(8'h77));
      end
      dbg_addr = 3'd6;
      #1;
      check("glitch_reg6", 32'(dbg_data), 32'(8'h77));
      $display("glitch/timing write: reg6=%02h", dbg_data);

      // ---- reset during the 4th data bit of a write ----
      i2c_start();
      write_byte(8'hA0, 1'b0, ack);
      write_byte(8'h00, 1'b0, ack);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      m_sda = 1'b0;
      wait_clk(4);
      scl_in = 1'b1;
      wait_clk(4);
      check("abort_busy_before", 32'(busy), 32'(1'b1));
      @(posedge core_clk);
      #2;
      rst = 1'b1;
      #1;
      check("abort_sda_out", 32'(sda_out), 32'(1'b1));
      check("abort_busy", 32'(busy), 32'(1'b0));
      check("abort_wr_addr", 32'(wr_addr), 32'(3'd0));
      check("abort_wr_data", 32'(wr_data), 32'(8'h00));
      check("abort_reg6_cleared", 32'(dbg_data), 32'(8'h00));
      wait_clk(2);
      scl_in = 1'b1;
      m_sda  = 1'b1;
      wait_clk(2);
      rst = 1'b0;
      wait_clk(4);
      $display("abort in data bit: sda_out=%0b busy=%0b", sda_out, busy);

      // ---- reset while the target is pulling SDA low for ACK ----
      i2c_start();
      for (int i = 7; i >= 0; i--) send_bit(1'((8'hA0 >> i) & 8'h01));
      check("abort_ack_driven", 32'(sda_out), 32'(1'b0));
      @(posedge core_clk);
      #2;
      rst = 1'b1;
      #1;
      check("abort_ack_released", 32'(sda_out), 32'(1'b1));
      wait_clk(2);
      scl_in = 1'b1;
      m_sda  = 1'b1;
      wait_clk(2);
      rst = 1'b0;
      wait_clk(4);
      $display("abort in ACK: sda_out=%0b", sda_out);

      // ---- full transaction after abort ----
      i2c_start();
      write_byte(8'hA0, 1'b0, ack);
      check("recover_addr_ack", 32'(ack), 32'(1'b1));
      write_byte(8'h04, 1'b0, ack);
      check("recover_ptr_ack", 32'(ack), 32'(1'b1));
      write_byte(8'h9C, 1'b0, ack);
      check("recover_data_ack", 32'(ack), 32'(1'b1));
      i2c_stop();
      for (int r = 0; r < 8; r++) begin
         dbg_addr = 3'(r);
         #1;
         check("recover_regfile", 32'(dbg_data), (r == 4) ? 32'(8'h9C) : 32'(8'h00));
      end
      $display("recovery write: reg4=9c expected, busy=%0b", busy);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
